spi_tx_master: RTL and testbench



---
 rtl/spi_tx_master.sv | 213 +++++++++++++++++++++
 tb/tb_spi_tx_master.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_master.sv
// SPI mode 0 master transmitter: valid/ready words are framed by SS and shifted out MSB first.
// Every SPI pin is a flop output; SCLK is clk divided by 2*P_CLK_DIV.
module spi_tx_master #(
  parameter int unsigned P_DATA_WIDTH = 8,
  parameter int unsigned P_CLK_DIV    = 10,
  parameter int unsigned P_CS_IDLE    = 100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [P_DATA_WIDTH-1:0] tx_data,
  input  logic                    tx_valid,
  input  logic                    tx_last,
  output logic                    tx_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    SPI0_SCLK_I,
  output logic                    SPI0_SS_I,
  output logic                    SPI0_MISO_I
);

  localparam int unsigned DivW = $clog2(P_CLK_DIV);
  localparam int unsigned BitW = $clog2(P_DATA_WIDTH + 1);
  localparam int unsigned GapW = $clog2(P_CS_IDLE + 1);

  localparam logic [DivW-1:0] DivLast = DivW'(P_CLK_DIV - 1);
  localparam logic [BitW-1:0] BitFull = BitW'(P_DATA_WIDTH);
  localparam logic [GapW-1:0] GapLast = GapW'(P_CS_IDLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StWait,
    StHold,
    StGap
  } state_e;

  state_e                  state_q, state_d;
  logic [DivW-1:0]         div_q, div_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [GapW-1:0]         gap_q, gap_d;
  logic [P_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                    last_q, last_d;
  logic                    sclk_q, sclk_d;
  logic                    ss_q, ss_d;
  logic                    miso_q, miso_d;
  logic                    done_q, done_d;
  logic                    init_q;

  logic div_term;
  logic word_end;
  logic hs;

  assign div_term = (div_q == DivLast);
  // Last high-SCLK cycle of a word; the following falling edge may chain the next word.
  assign word_end = (state_q == StShift) && sclk_q && div_term && (bit_q == BitFull);

  always_comb begin
    tx_ready = 1'b0;
    unique case (state_q)
      StIdle:  tx_ready = init_q;
      StWait:  tx_ready = 1'b1;
      StShift: tx_ready = word_end && !last_q;
      default: tx_ready = 1'b0;
    endcase
  end

  assign hs   = tx_valid && tx_ready;
  assign busy = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    last_d  = last_q;
    sclk_d  = sclk_q;
    ss_d    = ss_q;
    miso_d  = miso_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        ss_d   = 1'b1;
        sclk_d = 1'b0;
        miso_d = 1'b0;
        if (hs) begin
          shift_d = tx_data << 1;
          miso_d  = tx_data[P_DATA_WIDTH-1];
          last_d  = tx_last;
          ss_d    = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = StSetup;
        end
      end

      StSetup: begin
        if (div_term) begin
          // This rising edge is bit 0's, so the bit count starts at one.
          sclk_d  = 1'b1;
          div_d   = '0;
          bit_d   = BitW'(1);
          state_d = StShift;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StShift: begin
        if (!div_term) begin
          div_d = div_q + DivW'(1);
        end else begin
          div_d  = '0;
          sclk_d = !sclk_q;
          if (!sclk_q) begin
            bit_d = bit_q + BitW'(1);
          end else if (bit_q < BitFull) begin
            miso_d  = shift_q[P_DATA_WIDTH-1];
            shift_d = shift_q << 1;
          end else if (last_q) begin
            miso_d  = 1'b0;
            state_d = StHold;
          end else if (hs) begin
            shift_d = tx_data << 1;
            miso_d  = tx_data[P_DATA_WIDTH-1];
            last_d  = tx_last;
            bit_d   = '0;
          end else begin
            miso_d  = 1'b0;
            state_d = StWait;
          end
        end
      end

      StWait: begin
        sclk_d = 1'b0;
        if (hs) begin
          shift_d = tx_data << 1;
          miso_d  = tx_data[P_DATA_WIDTH-1];
          last_d  = tx_last;
          div_d   = '0;
          bit_d   = '0;
          state_d = StSetup;
        end
      end

      StHold: begin
        if (div_term) begin
          ss_d    = 1'b1;
          done_d  = 1'b1;
          gap_d   = '0;
          div_d   = '0;
          state_d = StGap;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StGap: begin
        if (gap_q == GapLast) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end

      default: begin
        ss_d    = 1'b1;
        sclk_d  = 1'b0;
        miso_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      last_q  <= 1'b0;
      sclk_q  <= 1'b0;
      ss_q    <= 1'b1;
      miso_q  <= 1'b0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      sclk_q  <= sclk_d;
      ss_q    <= ss_d;
      miso_q  <= miso_d;
      done_q  <= done_d;
      init_q  <= 1'b1;
    end
  end

  assign done        = done_q;
  assign SPI0_SCLK_I = sclk_q;
  assign SPI0_SS_I   = ss_q;
  assign SPI0_MISO_I = miso_q;

endmodule

// File: tb/tb_spi_tx_master.sv
// Bench for spi_tx_master: a timeline model (outputs as a function of cycles since the last
// accepted word) checked every cycle on two configurations, plus directed literal checks.
module tb_spi_tx_master;

  localparam int AD = 10, AW = 8, ACS = 100;
  localparam int BD = 2, BW = 16, BCS = 3;

  typedef struct packed {
    logic ss;
    logic sclk;
    logic miso;
    logic ready;
    logic busy;
    logic done;
  } exp_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs `off` cycles after a word was accepted (MSB visible at off = 0).
  function automatic exp_t predict(input bit have, input bit init, input longint off,
                                   input bit last, input logic [15:0] word,
                                   input int d, input int w, input int cs);
    exp_t   e;
    longint wl;
    int     idx;
    e    = '0;
    e.ss = 1'b1;
    wl   = longint'(2 * w * d);
    if (!have) begin
      e.ready = init;
    end else if (off < wl) begin
      idx     = w - 1 - int'(off / longint'(2 * d));
      e.ss    = 1'b0;
      e.busy  = 1'b1;
      e.sclk  = (off % longint'(2 * d)) >= longint'(d);
      e.miso  = word[idx];
      e.ready = (off == wl - 1) && !last;
    end else if (!last) begin
      e.ss    = 1'b0;
      e.busy  = 1'b1;
      e.ready = 1'b1;
    end else if (off < wl + d) begin
      e.ss   = 1'b0;
      e.busy = 1'b1;
    end else if (off < wl + d + cs) begin
      e.busy = 1'b1;
      e.done = (off == wl + d);
    end else begin
      e.ready = init;
    end
    return e;
  endfunction

  // ---------------- DUT A (defaults) ----------------
  logic        rst_a_n;
  logic [7:0]  tx_data_a;
  logic        tx_valid_a, tx_last_a;
  logic        ready_a, busy_a, done_a, sclk_a, ss_a, miso_a;

  spi_tx_master #(.P_DATA_WIDTH(AW), .P_CLK_DIV(AD), .P_CS_IDLE(ACS)) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_a_n),
    .tx_data     (tx_data_a),
    .tx_valid    (tx_valid_a),
    .tx_last     (tx_last_a),
    .tx_ready    (ready_a),
    .busy        (busy_a),
    .done        (done_a),
    .SPI0_SCLK_I (sclk_a),
    .SPI0_SS_I   (ss_a),
    .SPI0_MISO_I (miso_a)
  );

  // ---------------- DUT B (fast, wide) ----------------
  logic        rst_b_n;
  logic [15:0] tx_data_b;
  logic        tx_valid_b, tx_last_b;
  logic        ready_b, busy_b, done_b, sclk_b, ss_b, miso_b;

  spi_tx_master #(.P_DATA_WIDTH(BW), .P_CLK_DIV(BD), .P_CS_IDLE(BCS)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_b_n),
    .tx_data     (tx_data_b),
    .tx_valid    (tx_valid_b),
    .tx_last     (tx_last_b),
    .tx_ready    (ready_b),
    .busy        (busy_b),
    .done        (done_b),
    .SPI0_SCLK_I (sclk_b),
    .SPI0_SS_I   (ss_b),
    .SPI0_MISO_I (miso_b)
  );

  // ---------------- models ----------------
  exp_t        ea, eb;
  bit          have_a = 0, init_a = 0, last_a = 0, have_b = 0, init_b = 0, last_b = 0;
  longint      cyc_a = 0, wt_a = 0, cyc_b = 0, wt_b = 0;
  logic [15:0] word_a = '0, word_b = '0;
  int          hs_a = 0, hs_b = 0;

  always @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      have_a = 0;
      init_a = 0;
    end else begin
      cyc_a++;
      if (tx_valid_a && ea.ready) begin
        have_a = 1;
        wt_a   = cyc_a;
        word_a = {8'h00, tx_data_a};
        last_a = tx_last_a;
        hs_a++;
      end
      init_a = 1;
    end
    ea = predict(have_a, init_a, cyc_a - wt_a, last_a, word_a, AD, AW, ACS);
  end

  always @(posedge clk or negedge rst_b_n) begin
    if (!rst_b_n) begin
      have_b = 0;
      init_b = 0;
    end else begin
      cyc_b++;
      if (tx_valid_b && eb.ready) begin
        have_b = 1;
        wt_b   = cyc_b;
        word_b = tx_data_b;
        last_b = tx_last_b;
        hs_b++;
      end
      init_b = 1;
    end
    eb = predict(have_b, init_b, cyc_b - wt_b, last_b, word_b, BD, BW, BCS);
  end

  always @(negedge clk) begin
    check("A.ss", ss_a, ea.ss);
    check("A.sclk", sclk_a, ea.sclk);
    check("A.miso", miso_a, ea.miso);
    check("A.tx_ready", ready_a, ea.ready);
    check("A.busy", busy_a, ea.busy);
    check("A.done", done_a, ea.done);
    check("B.ss", ss_b, eb.ss);
    check("B.sclk", sclk_b, eb.sclk);
    check("B.miso", miso_b, eb.miso);
    check("B.tx_ready", ready_b, eb.ready);
    check("B.busy", busy_b, eb.busy);
    check("B.done", done_b, eb.done);
  end

  // ---------------- monitors ----------------
  logic [31:0] cap_a = '0, cap_b = '0;
  int          pulses_a = 0, pulses_b = 0, bad_a = 0, bad_b = 0;
  time         rise_t_a = 0, rise_t_b = 0;
  int          ss_low_a = 0, ss_low_b = 0, rdy_in_a = 0, done_cnt_a = 0;
  int          cyc_n = 0, t_ssr_a = 0, gap_len_a = 0, hr_a = 0, hrun_a = 0;
  logic        ss_prev_a = 1'b1, rdy_prev_a = 1'b0;

  always @(posedge sclk_a) begin
    cap_a = {cap_a[30:0], miso_a};
    pulses_a++;
    if (pulses_a > 1 && ($time - rise_t_a) != 400) bad_a++;
    rise_t_a = $time;
  end

  always @(posedge sclk_b) begin
    cap_b = {cap_b[30:0], miso_b};
    pulses_b++;
    if (pulses_b > 1 && ($time - rise_t_b) != 80) bad_b++;
    rise_t_b = $time;
  end

  always @(negedge clk) begin
    cyc_n++;
    if (!ss_a) ss_low_a++;
    if (!ss_b) ss_low_b++;
    if (!ss_a && ready_a) rdy_in_a++;
    if (done_a) done_cnt_a++;
    if (ss_a && !ss_prev_a) t_ssr_a = cyc_n;
    if (ready_a && !rdy_prev_a && ss_a) gap_len_a = cyc_n - t_ssr_a;
    if (ss_a) hr_a++;
    else begin
      if (ss_prev_a) hrun_a = hr_a;
      hr_a = 0;
    end
    ss_prev_a  = ss_a;
    rdy_prev_a = ready_a;
  end

  task automatic clear_mon();
    @(negedge clk);
    #2;
    cap_a = '0; cap_b = '0; pulses_a = 0; pulses_b = 0; bad_a = 0; bad_b = 0;
    ss_low_a = 0; ss_low_b = 0; rdy_in_a = 0; done_cnt_a = 0;
  endtask

  task automatic send_a(input logic [7:0] d, input logic last);
    int start;
    bit got;
    @(negedge clk);
    tx_valid_a = 1'b1;
    tx_data_a  = d;
    tx_last_a  = last;
    start      = hs_a;
    got        = 0;
    for (int i = 0; i < 5000 && !got; i++) begin
      @(posedge clk);
      #1;
      if (hs_a != start) got = 1;
    end
    check("A.handshake_taken", got, 1'b1);
  endtask

  task automatic send_b(input logic [15:0] d, input logic last);
    int start;
    bit got;
    @(negedge clk);
    tx_valid_b = 1'b1;
    tx_data_b  = d;
    tx_last_b  = last;
    start      = hs_b;
    got        = 0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(posedge clk);
      #1;
      if (hs_b != start) got = 1;
    end
    check("B.handshake_taken", got, 1'b1);
  endtask

  task automatic drop_a();
    @(negedge clk);
    tx_valid_a = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    tx_valid_a = 1'b0; tx_data_a = '0; tx_last_a = 1'b0;
    tx_valid_b = 1'b0; tx_data_b = '0; tx_last_b = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.ss", ss_a, 1'b1);
    check("reset.tx_ready", ready_a, 1'b0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single-word frame
    clear_mon();
    send_a(8'hA5, 1'b1);
    drop_a();
    repeat (320) @(negedge clk);
    check("single.capture", cap_a[7:0], 8'hA5);
    check("single.pulses", pulses_a, 8);
    check("single.ss_low_cycles", ss_low_a, 170);
    check("single.done_pulses", done_cnt_a, 1);
    check("single.ready_after_ss_rise", gap_len_a, 100);

    // Two-word frame, tx_valid held high
    clear_mon();
    send_a(8'h3C, 1'b0);
    send_a(8'hC3, 1'b1);
    drop_a();
    repeat (460) @(negedge clk);
    check("burst.capture", cap_a[15:0], 16'h3CC3);
    check("burst.pulses", pulses_a, 16);
    check("burst.bad_periods", bad_a, 0);
    check("burst.ready_in_frame", rdy_in_a, 1);
    check("burst.ss_low_cycles", ss_low_a, 330);

    // Stall between words
    clear_mon();
    send_a(8'h55, 1'b0);
    drop_a();
    repeat (500) @(negedge clk);
    check("stall.pulses_before_resume", pulses_a, 8);
    send_a(8'h81, 1'b1);
    drop_a();
    repeat (320) @(negedge clk);
    check("stall.capture", cap_a[15:0], 16'h5581);
    check("stall.pulses", pulses_a, 16);

    // Reset mid-frame
    clear_mon();
    send_a(8'hFF, 1'b1);
    drop_a();
    for (int i = 0; i < 200 && pulses_a < 3; i++) @(negedge clk);
    check("rst.reached_three_bits", pulses_a, 3);
    @(negedge clk);
    #3;
    rst_a_n = 1'b0;
    #1;
    check("rst.ss", ss_a, 1'b1);
    check("rst.sclk", sclk_a, 1'b0);
    check("rst.miso", miso_a, 1'b0);
    check("rst.busy", busy_a, 1'b0);
    check("rst.tx_ready", ready_a, 1'b0);
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    clear_mon();
    send_a(8'h5A, 1'b1);
    drop_a();
    repeat (320) @(negedge clk);
    check("rst.next_capture", cap_a[7:0], 8'h5A);
    check("rst.next_pulses", pulses_a, 8);

    // GAP enforcement
    send_a(8'hE7, 1'b1);
    drop_a();
    repeat (180) @(negedge clk);
    clear_mon();
    send_a(8'h12, 1'b1);
    drop_a();
    repeat (320) @(negedge clk);
    check("gap.ss_high_cycles", hrun_a, 101);
    check("gap.capture", cap_a[7:0], 8'h12);
    check("gap.pulses", pulses_a, 8);

    // Fast, wide configuration
    clear_mon();
    send_b(16'hBEEF, 1'b1);
    @(negedge clk);
    tx_valid_b = 1'b0;
    repeat (120) @(negedge clk);
    check("wide.capture", cap_b[15:0], 16'hBEEF);
    check("wide.pulses", pulses_b, 16);
    check("wide.bad_periods", bad_b, 0);
    check("wide.ss_low_cycles", ss_low_b, 66);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
